puf_eval_ctrl: RTL and testbench
================================

// Module: puf_eval_ctrl
// PURPOSE
//  Upstream driver and downstream collector for the N-stage arbiter PUF: generates LFSR challenges (sel),
//  launches the race edge (in), and resets the arbiter latch. It synchronises and samples the arbiter
//  output, then packs RESP_W evaluated bits into one response word with a 1-cycle valid strobe.
// PARAMETERS
//  N          128     challenge width; must equal arbiter N
//  POLY       128'hA000_0014_0000_0000_0000_0000_0000_0000  LFSR tap mask (x^128+x^126+x^101+x^99+1)
//  RESP_W     32      response bits per start request (>=2)
//  ARM_CYC    2       cycles arb_reset held high with race_in=0 before launch (>=1)
//  SETTLE_CYC 8       cycles race_in held high before sampling (>=3, covers 2-flop sync)
//  VOTES      5       evaluations per bit when MAJORITY_VOTE_EN defined (odd, >=3)
// PORTS
//  clk        in   1       system clock
//  reset      in   1       synchronous, active-high reset
//  start      in   1       begin a response word; accepted only when busy=0
//  seed       in   N       LFSR seed, captured on accepted start
//  challenge  out  N       drives arbiter sel
//  race_in    out  1       drives arbiter in (race launch edge)
//  arb_reset  out  1       drives arbiter reset
//  arb_out    in   1       arbiter out (asynchronous to clk)
//  busy       out  1       high from cycle after accepted start until resp_valid cycle inclusive
//  response   out  RESP_W  packed response word, held until next resp_valid
//  resp_valid out  1       1-cycle pulse: response updated
// BEHAVIOUR
//  Reset: every output 0, state IDLE, sync flops and counters 0. Reset mid-word aborts, no resp_valid.
//  FSM: IDLE -> ARM (ARM_CYC cyc: arb_reset=1, race_in=0) -> LAUNCH (SETTLE_CYC cyc: race_in=1,
//   arb_reset=0) -> SAMPLE (1 cyc: capture synced arb_out) -> NEXT (1 cyc: race_in=0, LFSR step,
//   bit_cnt++) -> ARM, or DONE when bit_cnt reaches RESP_W -> IDLE.
//  start in IDLE at edge T: challenge<=seed (seed==0 replaced by all-ones), busy=1 from T+1;
//   start while busy ignored. Simultaneous reset and start: reset wins.
//  LFSR step: fb = ^(challenge & POLY); challenge <= {challenge[N-2:0], fb}; stable through ARM..SAMPLE.
//  arb_out passes a 2-flop synchroniser; SAMPLE reads the second flop.
//  Packing: response shifts left, new bit at LSB; first evaluated bit ends in response[RESP_W-1].
//  Latency (no vote): resp_valid at T+1+RESP_W*(ARM_CYC+SETTLE_CYC+2); busy drops the cycle after.
//  bit_cnt width $clog2(RESP_W+1); wraps never (cleared on start).
// CONFIGURATION
//  MAJORITY_VOTE_EN defined: per bit, ARM..SAMPLE repeats VOTES times on the same challenge; ones
//   counter ($clog2(VOTES+1) bits) increments per sampled 1; bit = (ones > VOTES/2); NEXT after last
//   vote. Latency: T+1+RESP_W*(VOTES*(ARM_CYC+SETTLE_CYC+1)+1).
//  Undefined: single evaluation per bit; VOTES unused; no vote counter logic.
// STRUCTURE
//  puf_pkg: FSM state encoding (IDLE, ARM, LAUNCH, SAMPLE, NEXT, DONE), default POLY for N=64/128.
//  Sub-module puf_lfsr (load/step/seed-zero guard, parameter N, POLY); FSM, sync, packer in top.
// TESTING
//  Bench params: N=8, POLY=8'hB8, RESP_W=4, ARM_CYC=2, SETTLE_CYC=3; arbiter model returns challenge[0].
//  1 start at T=0, seed=8'h01 -> busy at 1, resp_valid at 29, response = challenge[0] sequence of 4 LFSR states.
//  2 seed=8'h00 -> first challenge=8'hFF, first bit 1 in response[3].
//  3 start pulsed at cycles 5 and 12 during busy -> ignored; exactly one resp_valid at 29.
//  4 reset asserted at cycle 15 -> all outputs 0 at 16, no resp_valid; new start completes normally.
//  5 arb_out tied 1 -> response=4'hF; tied 0 -> 4'h0; race_in/arb_reset never both 1.
//  6 MAJORITY_VOTE_EN, VOTES=3, arb_out pattern 1,0,1 per bit -> bit 1; 0,0,1 -> bit 0; resp_valid at 1+4*(3*6+1)=77.

Source files
------------

// File: rtl/puf_eval_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : puf_eval_ctrl_pkg                                                |
// | Brief   : Shared FSM encoding and default LFSR tap masks for the PUF ctrl  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package puf_eval_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_LAUNCH = 3'd2,
    S_SAMPLE = 3'd3,
    S_NEXT   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  // Tap bit i stands for x^(i+1) of the feedback polynomial.
  localparam logic [63:0]  c_POLY_64  = 64'hD800_0000_0000_0000;
  localparam logic [127:0] c_POLY_128 = 128'hA000_0014_0000_0000_0000_0000_0000_0000;

  function automatic logic [127:0] default_poly(input int n);
    return (n == 64) ? {64'd0, c_POLY_64} : c_POLY_128;
  endfunction

endpackage
`default_nettype wire

// File: rtl/puf_eval_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : puf_eval_ctrl_if                                                 |
// | Brief   : Request/response and arbiter-side signals of the PUF controller  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface puf_eval_ctrl_if #(
  parameter int N      = 128,
  parameter int RESP_W = 32
);
  import puf_eval_ctrl_pkg::*;

  logic              start;
  logic [N-1:0]      seed;
  logic [N-1:0]      challenge;
  logic              race_in;
  logic              arb_reset;
  logic              arb_out;
  logic              busy;
  logic [RESP_W-1:0] response;
  logic              resp_valid;

  modport master (
    output start, seed, arb_out,
    input  challenge, race_in, arb_reset, busy, response, resp_valid
  );

  modport slave (
    input  start, seed, arb_out,
    output challenge, race_in, arb_reset, busy, response, resp_valid
  );

endinterface
`default_nettype wire

// File: rtl/puf_eval_ctrl_lfsr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : puf_eval_ctrl_lfsr                                               |
// | Brief   : Challenge LFSR with seed load, step, and all-zero seed guard     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module puf_eval_ctrl_lfsr
  import puf_eval_ctrl_pkg::*;
#(
  parameter int           N    = 128,
  parameter logic [N-1:0] POLY = N'(default_poly(N))
) (
  input  wire logic         clk,
  input  wire logic         reset,
  input  wire logic         i_load,
  input  wire logic         i_step,
  input  wire logic [N-1:0] i_seed,
  output logic [N-1:0]      o_state
);

  logic [N-1:0] r_state;
  logic         w_fb;

  assign w_fb = ^(r_state & POLY);

  // An all-zero state would lock the LFSR, so a zero seed loads all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= '0;
    end else if (i_load) begin
      r_state <= (i_seed == '0) ? '1 : i_seed;
    end else if (i_step) begin
      r_state <= {r_state[N-2:0], w_fb};
    end
  end

  assign o_state = r_state;

endmodule
`default_nettype wire

// File: rtl/puf_eval_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : puf_eval_ctrl                                                    |
// | Brief   : Arbiter PUF driver/collector; MAJORITY_VOTE_EN adds per-bit vote |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module puf_eval_ctrl
  import puf_eval_ctrl_pkg::*;
#(
  parameter int           N          = 128,
  parameter logic [N-1:0] POLY       = N'(default_poly(N)),
  parameter int           RESP_W     = 32,
  parameter int           ARM_CYC    = 2,
  parameter int           SETTLE_CYC = 8
`ifdef MAJORITY_VOTE_EN
  , parameter int         VOTES      = 5
`endif
) (
  input  wire logic       clk,
  input  wire logic       reset,
  puf_eval_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(ARM_CYC + SETTLE_CYC + 1);
  localparam int BIT_W = $clog2(RESP_W + 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [CNT_W-1:0]  r_cyc_cnt;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic              r_sync1;
  logic              r_sync2;
  logic [RESP_W-1:0] r_shift;
  logic [RESP_W-1:0] r_response;
  logic [N-1:0]      w_challenge;
  logic              w_accept;
  logic              w_step;
  logic              w_arm_done;
  logic              w_settle_done;
  logic              w_last_bit;
  logic              w_last_vote;
  logic              w_bit;
  logic              w_race_in;
  logic              w_arb_reset;
  logic              w_busy;
  logic              w_resp_valid;

  assign w_accept      = (r_state == S_IDLE) && bus.start;
  assign w_step        = (r_state == S_NEXT);
  assign w_arm_done    = (r_cyc_cnt == CNT_W'(ARM_CYC - 1));
  assign w_settle_done = (r_cyc_cnt == CNT_W'(SETTLE_CYC - 1));
  assign w_last_bit    = (r_bit_cnt == BIT_W'(RESP_W - 1));

  puf_eval_ctrl_lfsr #(
    .N    (N),
    .POLY (POLY)
  ) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_accept),
    .i_step  (w_step),
    .i_seed  (bus.seed),
    .o_state (w_challenge)
  );

  // arb_out is asynchronous to clk; only the second flop is ever consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= bus.arb_out;
      r_sync2 <= r_sync1;
    end
  end

`ifdef MAJORITY_VOTE_EN
  localparam int VOTE_W = $clog2(VOTES + 1);

  logic [VOTE_W-1:0] r_ones;
  logic [VOTE_W-1:0] r_vote_cnt;
  logic [VOTE_W-1:0] w_ones_total;

  assign w_ones_total = r_ones + VOTE_W'(r_sync2);
  assign w_last_vote  = (r_vote_cnt == VOTE_W'(VOTES - 1));
  assign w_bit        = (w_ones_total > VOTE_W'(VOTES / 2));

  always_ff @(posedge clk) begin
    if (reset || w_accept || (r_state == S_NEXT)) begin
      r_ones     <= '0;
      r_vote_cnt <= '0;
    end else if (r_state == S_SAMPLE) begin
      r_ones     <= w_ones_total;
      r_vote_cnt <= r_vote_cnt + 1'b1;
    end
  end
`else
  assign w_last_vote = 1'b1;
  assign w_bit       = r_sync2;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cyc_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_response <= '0;
    end else begin
      if ((r_state == S_ARM && !w_arm_done) || (r_state == S_LAUNCH && !w_settle_done)) begin
        r_cyc_cnt <= r_cyc_cnt + 1'b1;
      end else begin
        r_cyc_cnt <= '0;
      end

      if (w_accept) begin
        r_bit_cnt <= '0;
      end else if (r_state == S_NEXT) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end

      // First evaluated bit migrates up to the MSB by the time the word is full.
      if (r_state == S_SAMPLE && w_last_vote) begin
        r_shift <= {r_shift[RESP_W-2:0], w_bit};
      end

      if (r_state == S_NEXT && w_last_bit) begin
        r_response <= r_shift;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_race_in    = 1'b0;
    w_arb_reset  = 1'b0;
    w_resp_valid = 1'b0;
    w_busy       = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (w_accept) w_state_next = S_ARM;
      end
      S_ARM: begin
        w_arb_reset = 1'b1;
        if (w_arm_done) w_state_next = S_LAUNCH;
      end
      S_LAUNCH: begin
        w_race_in = 1'b1;
        if (w_settle_done) w_state_next = S_SAMPLE;
      end
      S_SAMPLE: begin
        w_race_in    = 1'b1;
        w_state_next = w_last_vote ? S_NEXT : S_ARM;
      end
      S_NEXT: begin
        w_state_next = w_last_bit ? S_DONE : S_ARM;
      end
      S_DONE: begin
        w_resp_valid = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_busy       = 1'b0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign bus.challenge  = w_challenge;
  assign bus.race_in    = w_race_in;
  assign bus.arb_reset  = w_arb_reset;
  assign bus.busy       = w_busy;
  assign bus.response   = r_response;
  assign bus.resp_valid = w_resp_valid;

endmodule
`default_nettype wire

// File: tb/tb_puf_eval_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_puf_eval_ctrl                                                 |
// | Brief   : Directed bench for puf_eval_ctrl; arbiter model returns chal[0]  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_puf_eval_ctrl;

  localparam int N          = 8;
  localparam int RESP_W     = 4;
  localparam int ARM_CYC    = 2;
  localparam int SETTLE_CYC = 3;
`ifdef MAJORITY_VOTE_EN
  localparam int LAT = 77;
`else
  localparam int LAT = 29;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] arb_mode = 2'd0;
  logic       vote_bit = 1'b0;
  int         checks = 0;
  int         errors = 0;

  int         obs_lat;
  int         obs_nvalid;
  logic [3:0] obs_resp;
  logic [3:0] obs_resp_end;
  logic [7:0] obs_chal0;
  logic [7:0] obs_chal_done;
  logic       obs_busy1;
  logic       obs_busy_after;
  logic       obs_busy_gap;
  logic       obs_overlap;
  logic       obs_arm1;
  logic       obs_race3;

  puf_eval_ctrl_if #(.N(N), .RESP_W(RESP_W)) bus ();

  assign bus.arb_out = (arb_mode == 2'd0) ? bus.challenge[0] :
                       (arb_mode == 2'd1) ? 1'b1 :
                       (arb_mode == 2'd2) ? 1'b0 : vote_bit;

  puf_eval_ctrl #(
    .N          (N),
    .POLY       (8'hB8),
    .RESP_W     (RESP_W),
    .ARM_CYC    (ARM_CYC),
    .SETTLE_CYC (SETTLE_CYC)
`ifdef MAJORITY_VOTE_EN
    , .VOTES    (3)
`endif
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

`ifdef MAJORITY_VOTE_EN
  // Votes per bit: {1,0,1} {0,0,1} {1,1,0} {0,1,0}; LSB is the first launch.
  logic [11:0] vote_pat = 12'h4E5;
  int          launch_idx = 0;
  always @(posedge bus.race_in) begin
    if (arb_mode == 2'd3) begin
      vote_bit = (launch_idx < 12) ? vote_pat[launch_idx] : 1'b0;
      launch_idx++;
    end
  end
`endif

  // Cycle k is the interval sampled #1 after the k-th edge following the start request.
  task automatic run_word(input logic [7:0] s, input bit pulse);
    obs_lat        = -1;
    obs_nvalid     = 0;
    obs_resp       = 4'h0;
    obs_resp_end   = 4'h0;
    obs_chal0      = 8'h00;
    obs_chal_done  = 8'h00;
    obs_busy1      = 1'b0;
    obs_busy_after = 1'b1;
    obs_busy_gap   = 1'b0;
    obs_overlap    = 1'b0;
    obs_arm1       = 1'b0;
    obs_race3      = 1'b0;
    bus.seed  = s;
    bus.start = 1'b1;
    for (int k = 1; k <= LAT + 3; k++) begin
      @(posedge clk); #1;
      bus.start = pulse && (k == 5 || k == 12);
      if (pulse && (k == 5 || k == 12)) bus.seed = 8'h01;
      if (k == 1) begin
        obs_busy1 = bus.busy;
        obs_chal0 = bus.challenge;
        obs_arm1  = bus.arb_reset;
      end
      if (k == 3) obs_race3 = bus.race_in;
      if (bus.race_in && bus.arb_reset) obs_overlap = 1'b1;
      if (bus.resp_valid) begin
        obs_nvalid++;
        if (obs_lat < 0) begin
          obs_lat       = k;
          obs_resp      = bus.response;
          obs_chal_done = bus.challenge;
        end
      end
      if (obs_lat < 0 && !bus.busy) obs_busy_gap = 1'b1;
      if (obs_lat >= 0 && k == obs_lat + 1) obs_busy_after = bus.busy;
      if (k == LAT + 3) obs_resp_end = bus.response;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.start = 1'b1; bus.seed = 8'h55;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.challenge !== 8'h00) begin errors++; $display("FAIL rst_challenge: got %h expected 00", bus.challenge); end
    checks++; if (bus.race_in !== 1'b0 || bus.arb_reset !== 1'b0) begin errors++; $display("FAIL rst_arb_ctl: got race_in=%b arb_reset=%b expected 0 0", bus.race_in, bus.arb_reset); end
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", bus.resp_valid); end
    checks++; if (bus.response !== 4'h0) begin errors++; $display("FAIL rst_response: got %h expected 0", bus.response); end
    reset = 1'b0; bus.start = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_start_lost: got busy=%b expected 0", bus.busy); end
  endtask

  task automatic test_basic();
    run_word(8'h01, 1'b0);
    checks++; if (obs_busy1 !== 1'b1) begin errors++; $display("FAIL basic_busy1: got %b expected 1", obs_busy1); end
    checks++; if (obs_chal0 !== 8'h01) begin errors++; $display("FAIL basic_chal0: got %h expected 01", obs_chal0); end
    checks++; if (obs_arm1 !== 1'b1 || obs_race3 !== 1'b1) begin errors++; $display("FAIL basic_phases: got arm@1=%b race@3=%b expected 1 1", obs_arm1, obs_race3); end
    checks++; if (obs_lat !== LAT) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", obs_lat, LAT); end
    checks++; if (obs_resp !== 4'h8) begin errors++; $display("FAIL basic_response: got %h expected 8", obs_resp); end
    checks++; if (obs_chal_done !== 8'h11) begin errors++; $display("FAIL basic_chal_final: got %h expected 11", obs_chal_done); end
    checks++; if (obs_busy_gap !== 1'b0 || obs_busy_after !== 1'b0) begin errors++; $display("FAIL basic_busy_window: got gap=%b after=%b expected 0 0", obs_busy_gap, obs_busy_after); end
    checks++; if (obs_resp_end !== 4'h8) begin errors++; $display("FAIL basic_hold: got %h expected 8", obs_resp_end); end
    run_word(8'hB5, 1'b0);
    checks++; if (obs_resp !== 4'hC) begin errors++; $display("FAIL b5_response: got %h expected C", obs_resp); end
    checks++; if (obs_chal_done !== 8'h59) begin errors++; $display("FAIL b5_chal_final: got %h expected 59", obs_chal_done); end
  endtask

  task automatic test_seed_zero();
    run_word(8'h00, 1'b0);
    checks++; if (obs_chal0 !== 8'hFF) begin errors++; $display("FAIL zero_chal0: got %h expected FF", obs_chal0); end
    checks++; if (obs_resp !== 4'h8) begin errors++; $display("FAIL zero_response: got %h expected 8", obs_resp); end
    checks++; if (obs_chal_done !== 8'hF0) begin errors++; $display("FAIL zero_chal_final: got %h expected F0", obs_chal_done); end
  endtask

  task automatic test_start_ignored();
    run_word(8'hB5, 1'b1);
    checks++; if (obs_nvalid !== 1) begin errors++; $display("FAIL ign_valid_count: got %0d expected 1", obs_nvalid); end
    checks++; if (obs_lat !== LAT) begin errors++; $display("FAIL ign_latency: got %0d expected %0d", obs_lat, LAT); end
    checks++; if (obs_resp !== 4'hC) begin errors++; $display("FAIL ign_response: got %h expected C", obs_resp); end
  endtask

  task automatic test_reset_midword();
    int nvalid;
    bus.seed = 8'hB5; bus.start = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b0 || bus.resp_valid !== 1'b0) begin errors++; $display("FAIL mid_ctl: got busy=%b valid=%b expected 0 0", bus.busy, bus.resp_valid); end
    checks++; if (bus.race_in !== 1'b0 || bus.arb_reset !== 1'b0) begin errors++; $display("FAIL mid_arb: got race_in=%b arb_reset=%b expected 0 0", bus.race_in, bus.arb_reset); end
    checks++; if (bus.challenge !== 8'h00) begin errors++; $display("FAIL mid_challenge: got %h expected 00", bus.challenge); end
    checks++; if (bus.response !== 4'h0) begin errors++; $display("FAIL mid_response: got %h expected 0", bus.response); end
    reset = 1'b0;
    nvalid = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.resp_valid) nvalid++;
    end
    checks++; if (nvalid !== 0) begin errors++; $display("FAIL mid_no_valid: got %0d expected 0", nvalid); end
    run_word(8'hB5, 1'b0);
    checks++; if (obs_lat !== LAT || obs_resp !== 4'hC) begin errors++; $display("FAIL mid_restart: got lat=%0d resp=%h expected %0d C", obs_lat, obs_resp, LAT); end
  endtask

  task automatic test_tied();
    arb_mode = 2'd1;
    run_word(8'hB5, 1'b0);
    checks++; if (obs_resp !== 4'hF) begin errors++; $display("FAIL tied1_response: got %h expected F", obs_resp); end
    checks++; if (obs_overlap !== 1'b0) begin errors++; $display("FAIL tied1_overlap: got %b expected 0", obs_overlap); end
    arb_mode = 2'd2;
    run_word(8'hB5, 1'b0);
    checks++; if (obs_resp !== 4'h0) begin errors++; $display("FAIL tied0_response: got %h expected 0", obs_resp); end
    checks++; if (obs_overlap !== 1'b0 || obs_lat !== LAT) begin errors++; $display("FAIL tied0_overlap_lat: got ovl=%b lat=%0d expected 0 %0d", obs_overlap, obs_lat, LAT); end
    arb_mode = 2'd0;
  endtask

`ifdef MAJORITY_VOTE_EN
  task automatic test_vote();
    launch_idx = 0;
    vote_bit   = 1'b0;
    arb_mode   = 2'd3;
    run_word(8'hB5, 1'b0);
    checks++; if (obs_resp !== 4'hA) begin errors++; $display("FAIL vote_response: got %h expected A", obs_resp); end
    checks++; if (obs_lat !== 77) begin errors++; $display("FAIL vote_latency: got %0d expected 77", obs_lat); end
    checks++; if (launch_idx !== 12) begin errors++; $display("FAIL vote_launches: got %0d expected 12", launch_idx); end
    arb_mode = 2'd0;
  endtask
`endif

  initial begin
    bus.start = 1'b0;
    bus.seed  = 8'h00;
    test_reset();
    test_basic();
    test_seed_zero();
    test_start_ignored();
    test_reset_midword();
    test_tied();
`ifdef MAJORITY_VOTE_EN
    test_vote();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
